sum_norm: RTL and testbench
===========================

# sum_norm

Per-core normalization stage that sits directly downstream of the cross-core sum FIFO. It combines the core's local sum with the remote sum popped from the FIFO into a total, then divides each column psum by that total using a bit-serial restoring divider. The result is a signed fixed-point normalized output vector. One instance per core runs on that core's clock and is the sole reader of the FIFO feeding that core.

## Interface
- `col`, 8, number of psum columns
- `bw_psum`, 20, signed psum width per column
- `bw_sum`, 24, unsigned local/remote sum width (bw_psum+4)
- `frac`, 8, fractional bits of the normalized output
- `bw_out`, 16, signed normalized output width per column
- `clk`  in  1  core clock; all logic rising-edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  request to normalize; accepted only in IDLE
- `psum_in`  in  bw_psum*col  signed psums; column c at [c*bw_psum +: bw_psum]; sampled on the start-accept edge
- `sum_local`  in  bw_sum  local sum; sampled on the start-accept edge
- `sum_remote`  in  bw_sum  FIFO head data (first-word-fall-through)
- `remote_valid`  in  1  FIFO not empty
- `rd`  out  1  FIFO pop strobe
- `out_ready`  in  1  consumer accepts `norm_out`
- `norm_out`  out  bw_out*col  signed normalized results, same column packing
- `out_valid`  out  1  `norm_out` valid
- `busy`  out  1  high in any state other than IDLE
- `div_zero`  out  1  total was 0 for the current result

## Operation
- States: IDLE, WAIT_REMOTE, ADD, DIV, DONE.
- IDLE: `start`=1 latches psums and `sum_local`, then goes to WAIT_REMOTE.
- WAIT_REMOTE: `rd` = `remote_valid` (combinational, exactly one pulse per job). On the edge where `rd`=1, capture `sum_remote` and go to ADD. Otherwise wait indefinitely.
- ADD: `total = sum_local + sum_remote`, width bw_sum+1 with no overflow. If total==0, set `div_zero`, clear all outputs, and go to DONE. Otherwise go to DIV with column index 0.
- DIV, per column:
  - Dividend = |psum| << frac, N = bw_psum+frac bits.
  - Run N restoring iterations, one quotient bit per cycle, plus 1 finalize cycle: round (per macro), saturate, restore sign, write the column.
  - Each column takes N+1 cycles. After column col-1, go to DONE.
- Saturation:
  - Positive magnitudes saturate to 2^(bw_out-1)-1.
  - Negative magnitudes saturate to -2^(bw_out-1).
  - |psum| of the most negative value is computed in bw_psum+1 bits.
- DONE: `out_valid`=1 and `norm_out` is held stable. When `out_ready`=1, return to IDLE. `out_valid` falls on that edge.
- `start` while not in IDLE is ignored. `start` and `out_ready` in the same DONE cycle do not chain; the new `start` needs IDLE.
- `reset` asserted (at any time): state→IDLE, `norm_out`=0, `out_valid`=0, `div_zero`=0, `busy`=0, `rd`=0. An in-flight job is discarded and no pop occurs during reset.

## Timing
- Let edge 0 be the start-accept edge. With `remote_valid` already high, `rd`=1 in cycle 0→1 and capture happens at edge 1.
- ADD completes at edge 2.
- DIV occupies col*(N+1) cycles. Defaults: 8*29 = 232.
- `out_valid` rises at edge 234 (defaults). Each cycle of `remote_valid` low in WAIT_REMOTE adds one cycle.
- In the total==0 path, `out_valid` rises at edge 2.
- `busy` rises at edge 0 and falls when leaving DONE.

## Configuration
- `SUM_NORM_ROUND_EN` defined: after the last iteration, if 2*remainder >= total, add 1 to the magnitude before saturation (round half up on magnitude).
- Not defined: quotient is truncated toward zero. Cycle counts are identical in both modes.

## Structure
- Package `sum_norm_pkg`:
  - state enum
  - localparams N = bw_psum+frac, total width bw_sum+1, remainder width bw_sum+2
  - saturation limits
- Sub-module `seq_div_restoring`: unsigned N-bit dividend, (bw_sum+1)-bit divisor, `load`/`done` handshake, one bit per cycle, returns quotient and remainder.
- The parent owns the FSM, column index, sign handling, rounding, saturation and output registers.

## Test plan
- Basic: psum col0=100, col1=-100, others 0; local=150, remote=250 → col0=64, col1=-64, others 0. `out_valid` at edge 234; exactly one `rd` pulse.
- Remote late: `remote_valid` held low for 10 cycles after start → `rd` only once, on the cycle it rises; `out_valid` at edge 244; `busy` high throughout.
- Rounding: psum=2, total=3 (local 1, remote 2) → 171 with `SUM_NORM_ROUND_EN`, 170 without. psum=1, total=3 → 85 in both modes.
- Saturation/zero:
  - psum=200, total=1 → 32767.
  - psum=-200, total=1 → -32768.
  - local=remote=0 → all 0, `div_zero`=1, `out_valid` at edge 2.
- Backpressure/ignore: hold `out_ready`=0 for 20 cycles in DONE and pulse `start` → outputs stable, `start` ignored, no `rd`. Then `out_ready`=1 returns to IDLE.
- Reset mid-DIV: assert `reset` at edge 100 → all outputs 0 immediately, `rd`=0. After release, a fresh job completes correctly.

Source files
------------

// File: rtl/sum_norm_pkg.sv
// Shared constants, state encoding and saturation limits for the sum_norm stage.
// Optional rounding is selected by the SUM_NORM_ROUND_EN macro in sum_norm.sv.
package sum_norm_pkg;

  localparam int COL     = 8;
  localparam int BW_PSUM = 20;
  localparam int BW_SUM  = 24;
  localparam int FRAC    = 8;
  localparam int BW_OUT  = 16;

  localparam int N      = BW_PSUM + FRAC;
  localparam int BW_TOT = BW_SUM + 1;
  localparam int BW_REM = BW_SUM + 2;
  localparam int IDX_W  = $clog2(COL);

  localparam logic [BW_OUT-1:0] SAT_POS = {1'b0, {(BW_OUT-1){1'b1}}};
  localparam logic [BW_OUT-1:0] SAT_NEG = {1'b1, {(BW_OUT-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_REMOTE,
    S_ADD,
    S_DIV,
    S_DONE
  } state_t;

endpackage

// File: rtl/sum_norm_seq_div.sv
// Bit-serial restoring divider: one quotient bit per cycle, N cycles after load.
// o_done is high whenever no division is in progress.
module seq_div_restoring #(
  parameter int N    = 28,
  parameter int BW_D = 25
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_load,
  input  logic [N-1:0]    i_dividend,
  input  logic [BW_D-1:0] i_divisor,
  output logic            o_done,
  output logic [N-1:0]    o_quotient,
  output logic [BW_D:0]   o_remainder
);

  localparam int CW = $clog2(N + 1);

  logic [BW_D:0]   r_rem;
  logic [N-1:0]    r_quo;
  logic [BW_D-1:0] r_div;
  logic [CW-1:0]   r_cnt;

  logic [BW_D:0]   w_shift;
  logic [BW_D:0]   w_diff;
  logic            w_ge;

  // Remainder stays below the divisor, so its low BW_D bits carry all of it.
  assign w_shift = {r_rem[BW_D-1:0], r_quo[N-1]};
  assign w_ge    = (w_shift >= {1'b0, r_div});
  assign w_diff  = w_shift - {1'b0, r_div};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rem <= '0;
      r_quo <= '0;
      r_div <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_rem <= '0;
      r_quo <= i_dividend;
      r_div <= i_divisor;
      r_cnt <= CW'(N);
    end else if (r_cnt != '0) begin
      r_rem <= w_ge ? w_diff : w_shift;
      r_quo <= {r_quo[N-2:0], w_ge};
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done      = (r_cnt == '0);
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

endmodule

// File: rtl/sum_norm.sv
// Normalizes each column psum by (local + remote sum) into signed fixed point.
// Define SUM_NORM_ROUND_EN for round-half-up on magnitude; default truncates.
module sum_norm
  import sum_norm_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [BW_PSUM*COL-1:0]  psum_in,
  input  logic [BW_SUM-1:0]       sum_local,
  input  logic [BW_SUM-1:0]       sum_remote,
  input  logic                    remote_valid,
  output logic                    rd,
  input  logic                    out_ready,
  output logic [BW_OUT*COL-1:0]   norm_out,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    div_zero,
  output state_t                  dbg_state
);

  state_t                   r_state;
  logic [BW_PSUM*COL-1:0]   r_psum;
  logic [BW_SUM-1:0]        r_local;
  logic [BW_SUM-1:0]        r_remote;
  logic [BW_TOT-1:0]        r_total;
  logic [IDX_W-1:0]         r_idx;
  logic [BW_OUT*COL-1:0]    r_norm;
  logic                     r_valid;
  logic                     r_dz;

  logic [BW_TOT-1:0]        w_total_add;
  logic                     w_last;
  logic                     w_load;
  logic [IDX_W-1:0]         w_load_idx;
  logic [BW_PSUM-1:0]       w_psum_sel;
  logic [BW_PSUM-1:0]       w_abs;
  logic [N-1:0]             w_dividend;
  logic [BW_TOT-1:0]        w_divisor;
  logic                     w_done;
  logic [N-1:0]             w_quo;
  logic                     w_round_up;
  logic [N:0]               w_mag;
  logic                     w_sign;
  logic [BW_OUT-1:0]        w_col_out;

  assign w_total_add = {1'b0, r_local} + {1'b0, r_remote};
  assign w_last      = (r_idx == IDX_W'(COL - 1));
  assign w_load      = ((r_state == S_ADD) && (w_total_add != '0)) ||
                       ((r_state == S_DIV) && w_done && !w_last);
  assign w_load_idx  = (r_state == S_ADD) ? '0 : r_idx + 1'b1;
  assign w_psum_sel  = r_psum[w_load_idx*BW_PSUM +: BW_PSUM];
  // Unsigned two's-complement negate yields 2^(BW_PSUM-1) for the most negative psum.
  assign w_abs       = w_psum_sel[BW_PSUM-1] ? (~w_psum_sel + 1'b1) : w_psum_sel;
  assign w_dividend  = {w_abs, {FRAC{1'b0}}};
  assign w_divisor   = (r_state == S_ADD) ? w_total_add : r_total;

`ifdef SUM_NORM_ROUND_EN
  logic [BW_REM-1:0] w_rem;
  seq_div_restoring #(.N(N), .BW_D(BW_TOT)) u_div (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_load      (w_load),
    .i_dividend  (w_dividend),
    .i_divisor   (w_divisor),
    .o_done      (w_done),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );
  assign w_round_up = ({w_rem, 1'b0} >= {2'b00, r_total});
`else
  seq_div_restoring #(.N(N), .BW_D(BW_TOT)) u_div (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_load      (w_load),
    .i_dividend  (w_dividend),
    .i_divisor   (w_divisor),
    .o_done      (w_done),
    .o_quotient  (w_quo),
    .o_remainder ()
  );
  assign w_round_up = 1'b0;
`endif

  assign w_mag  = {1'b0, w_quo} + (N+1)'(w_round_up);
  assign w_sign = r_psum[r_idx*BW_PSUM + (BW_PSUM - 1)];

  always_comb begin
    w_col_out = '0;
    if (w_sign) begin
      w_col_out = (w_mag > (N+1)'(SAT_NEG)) ? SAT_NEG : (~w_mag[BW_OUT-1:0] + BW_OUT'(1));
    end else begin
      w_col_out = (w_mag > (N+1)'(SAT_POS)) ? SAT_POS : w_mag[BW_OUT-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_psum   <= '0;
      r_local  <= '0;
      r_remote <= '0;
      r_total  <= '0;
      r_idx    <= '0;
      r_norm   <= '0;
      r_valid  <= 1'b0;
      r_dz     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_psum  <= psum_in;
            r_local <= sum_local;
            r_dz    <= 1'b0;
            r_state <= S_WAIT_REMOTE;
          end
        end
        S_WAIT_REMOTE: begin
          if (remote_valid) begin
            r_remote <= sum_remote;
            r_state  <= S_ADD;
          end
        end
        S_ADD: begin
          r_total <= w_total_add;
          r_idx   <= '0;
          if (w_total_add == '0) begin
            r_dz    <= 1'b1;
            r_norm  <= '0;
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_DIV;
          end
        end
        S_DIV: begin
          // The cycle the divider reports done is the finalize cycle for r_idx.
          if (w_done) begin
            r_norm[r_idx*BW_OUT +: BW_OUT] <= w_col_out;
            if (w_last) begin
              r_valid <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd        = (r_state == S_WAIT_REMOTE) && remote_valid;
  assign norm_out  = r_norm;
  assign out_valid = r_valid;
  assign busy      = (r_state != S_IDLE);
  assign div_zero  = r_dz;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_sum_norm.sv
// Scoreboard bench for sum_norm: arithmetic reference model, random and directed jobs.
// Handshake: out_valid/norm_out hold until the edge where out_ready is high.
module tb_sum_norm;
  import sum_norm_pkg::*;

  localparam int W       = 1 + BW_OUT*COL;
  localparam int PW      = BW_PSUM*COL;
  localparam int DIV_LAT = 2 + COL*(N+1);

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  start = 1'b0;
  logic [PW-1:0]         psum_in = '0;
  logic [BW_SUM-1:0]     sum_local = '0;
  logic [BW_SUM-1:0]     sum_remote = '0;
  logic                  remote_valid = 1'b0;
  logic                  rd;
  logic                  out_ready = 1'b0;
  logic [BW_OUT*COL-1:0] norm_out;
  logic                  out_valid;
  logic                  busy;
  logic                  div_zero;
  state_t                dbg_state;

  int unsigned cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int rd_cnt = 0;
  logic [W-1:0] exp_q[$];
  int unsigned  rise_q[$];

  sum_norm dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .psum_in      (psum_in),
    .sum_local    (sum_local),
    .sum_remote   (sum_remote),
    .remote_valid (remote_valid),
    .rd           (rd),
    .out_ready    (out_ready),
    .norm_out     (norm_out),
    .out_valid    (out_valid),
    .busy         (busy),
    .div_zero     (div_zero),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got event expected none at cycle %0d", name, cyc);
  endtask

  // Reference: signed psum * 2^FRAC / total, optional round, clamp to output range.
  function automatic logic [W-1:0] model(input logic [PW-1:0] ps, input longint loc, input longint rem);
    logic [W-1:0] r;
    longint total, p, mag, num, q, rr, v;
    logic signed [BW_PSUM-1:0] t;
    r = '0;
    total = loc + rem;
    if (total == 0) begin
      r[W-1] = 1'b1;
    end else begin
      for (int c = 0; c < COL; c++) begin
        t   = ps[c*BW_PSUM +: BW_PSUM];
        p   = longint'(t);
        mag = (p < 0) ? -p : p;
        num = mag * (longint'(1) << FRAC);
        q   = num / total;
        rr  = num % total;
`ifdef SUM_NORM_ROUND_EN
        if (2*rr >= total) q = q + 1;
`endif
        if (p < 0) v = (q > (longint'(1) << (BW_OUT-1))) ? -(longint'(1) << (BW_OUT-1)) : -q;
        else       v = (q > (longint'(1) << (BW_OUT-1)) - 1) ? (longint'(1) << (BW_OUT-1)) - 1 : q;
        r[c*BW_OUT +: BW_OUT] = v[BW_OUT-1:0];
      end
    end
    return r;
  endfunction

  function automatic logic [PW-1:0] ps2(input int a, input int b);
    logic [PW-1:0] v;
    logic [31:0] ta, tb;
    ta = a;
    tb = b;
    v = '0;
    v[0 +: BW_PSUM]       = ta[BW_PSUM-1:0];
    v[BW_PSUM +: BW_PSUM] = tb[BW_PSUM-1:0];
    return v;
  endfunction

  function automatic logic [PW-1:0] ps_rand();
    logic [PW-1:0] v;
    logic [31:0] r;
    for (int c = 0; c < COL; c++) begin
      r = $urandom;
      v[c*BW_PSUM +: BW_PSUM] = r[BW_PSUM-1:0];
    end
    return v;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic         prev_valid = 1'b0;
  logic [W-1:0] held;
  int unsigned  rise_cyc = 0;

  always @(negedge clk) begin
    if (rd) rd_cnt++;
    if (out_valid && !prev_valid) begin
      if (rise_q.size() == 0) fail_now("unexpected_valid");
      else check("valid_edge", W'(cyc), W'(rise_q.pop_front()));
      held = {div_zero, norm_out};
      rise_cyc = cyc;
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) fail_now("unexpected_output");
      else check("result", {div_zero, norm_out}, exp_q.pop_front());
      if (cyc != rise_cyc) check("held_stable", {div_zero, norm_out}, held);
    end
    prev_valid = out_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    remote_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    rise_q.delete();
  endtask

  task automatic run_job(input logic [PW-1:0] ps, input logic [BW_SUM-1:0] loc,
                         input logic [BW_SUM-1:0] rem, input int delay, input int hold,
                         input bit poke);
    int unsigned s0;
    int t;
    longint total;
    logic [31:0] r;
    total = longint'(loc) + longint'(rem);
    psum_in = ps;
    sum_local = loc;
    sum_remote = rem;
    remote_valid = (delay == 0);
    rd_cnt = 0;
    start = 1'b1;
    @(posedge clk); #1;
    s0 = cyc;
    exp_q.push_back(model(ps, longint'(loc), longint'(rem)));
    rise_q.push_back(s0 + ((total == 0) ? 2 : DIV_LAT) + delay);
    start = 1'b0;
    psum_in = ps_rand();
    r = $urandom;
    sum_local = r[BW_SUM-1:0];
    repeat (delay) begin @(posedge clk); #1; end
    if (delay > 0) begin
      check("busy_wait_remote", W'(busy), W'(1));
      check("no_rd_while_empty", W'(rd_cnt), W'(0));
    end
    remote_valid = 1'b1;
    @(posedge clk); #1;
    remote_valid = 1'b0;
    r = $urandom;
    sum_remote = r[BW_SUM-1:0];
    if (poke && total != 0) begin
      repeat (40) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    t = 0;
    while (!out_valid && t < 4000) begin @(posedge clk); #1; t++; end
    if (!out_valid) begin
      fail_now("out_valid_timeout");
      do_reset();
      return;
    end
    for (int i = 0; i < hold; i++) begin
      start = poke && (i == hold/2);
      @(posedge clk); #1;
      start = 1'b0;
    end
    if (hold > 0) check("busy_in_done", W'({busy, out_valid}), W'(2'b11));
    out_ready = 1'b1;
    start = poke;
    @(posedge clk); #1;
    out_ready = 1'b0;
    start = 1'b0;
    check("released_idle", W'({out_valid, busy}), W'(0));
    check("rd_pulses", W'(rd_cnt), W'(1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] r1, r2;
    int mode;
    int unsigned s0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_norm", {1'b0, norm_out}, '0);
    check("reset_flags", W'({out_valid, busy, div_zero, rd}), '0);
    check("reset_state", W'(dbg_state), W'(S_IDLE));
    reset = 1'b0;
    @(posedge clk); #1;

    run_job(ps2(100, -100), 24'd150, 24'd250, 0, 0, 1'b0);
    run_job(ps2(100, -100), 24'd150, 24'd250, 10, 0, 1'b0);
    run_job(ps2(2, 1), 24'd1, 24'd2, 0, 1, 1'b0);
    run_job(ps2(1, -2), 24'd1, 24'd2, 0, 0, 1'b0);
    run_job(ps2(200, -200), 24'd1, 24'd0, 0, 0, 1'b0);
    run_job(ps2(-524288, 524287), 24'd0, 24'd1, 1, 0, 1'b0);
    run_job(ps2(-524288, 524287), 24'hFFFFFF, 24'hFFFFFF, 0, 0, 1'b0);
    run_job(ps_rand(), 24'd0, 24'd0, 2, 0, 1'b0);
    run_job(ps2(300, -7), 24'd1000, 24'd24, 0, 20, 1'b1);

    // abort a job mid-division; a fresh job must then complete normally
    psum_in = ps_rand();
    sum_local = 24'd77;
    sum_remote = 24'd5;
    remote_valid = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    s0 = cyc;
    start = 1'b0;
    @(posedge clk); #1;
    remote_valid = 1'b0;
    while (cyc < s0 + 100) @(posedge clk);
    #1;
    reset = 1'b1;
    remote_valid = 1'b1;
    #1;
    check("reset_mid_norm", {1'b0, norm_out}, '0);
    check("reset_mid_flags", W'({out_valid, busy, div_zero, rd}), '0);
    @(posedge clk); #1;
    reset = 1'b0;
    remote_valid = 1'b0;
    @(posedge clk); #1;
    run_job(ps2(-100, 100), 24'd150, 24'd250, 0, 0, 1'b0);

    for (int j = 0; j < 12; j++) begin
      mode = $urandom_range(0, 3);
      r1 = $urandom;
      r2 = $urandom;
      case (mode)
        0: begin r1 = $urandom_range(0, 3);    r2 = $urandom_range(0, 3);    end
        1: begin r1 = $urandom_range(0, 1000); r2 = $urandom_range(0, 1000); end
        2: begin r1 = r1 & 32'h0000_FFFF;      r2 = r2 & 32'h0000_FFFF;      end
        default: ;
      endcase
      run_job(ps_rand(), r1[BW_SUM-1:0], r2[BW_SUM-1:0], $urandom_range(0, 3),
              $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) fail_now("leftover_expected");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    fail_now("global_timeout");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
